// File: rtl/dac_sample_pacer_if.sv
// Sample-in and DAC-out handshake bundle for dac_sample_pacer.
// The pacer side uses the master modport; the ADC receiver and DAC transmitter side uses the slave modport.
interface dac_sample_pacer_if;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        dac_busy;
    logic [23:0] dac_data;
    logic        dac_send;

    modport master (
        input  sample_in,
        input  sample_valid,
        input  dac_busy,
        output dac_data,
        output dac_send
    );

    modport slave (
        output sample_in,
        output sample_valid,
        output dac_busy,
        input  dac_data,
        input  dac_send
    );
endinterface

// File: rtl/dac_sample_pacer.sv
// Buffers ADC samples in a 4-deep FIFO and releases one command-prefixed DAC word per fixed send slot.
// Reports sticky overflow, underrun and late-slot status.
module dac_sample_pacer #(
    parameter int unsigned SEND_INTERVAL = 3624,
    parameter logic [7:0]  CHANNEL_CMD   = 8'b00110001
) (
    input  logic                clock,
    input  logic                rstn,
    dac_sample_pacer_if.master  bus,
    input  logic                clear_flags,
    output logic [2:0]          fifo_level,
    output logic                overflow,
    output logic                underrun,
    output logic                late
);
    localparam int unsigned CNT_W       = (SEND_INTERVAL > 1) ? $clog2(SEND_INTERVAL) : 1;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned PTR_W       = 2;
    localparam int unsigned LVL_W       = 3;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned WORD_W      = 24;
    localparam int unsigned ACK_W       = 2;
    localparam int unsigned ACK_TIMEOUT = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEND_INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, ACK, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [WORD_W-1:0]  dac_data_q, dac_data_d;
    logic               dac_send_q, dac_send_d;
    logic               overflow_q, overflow_d, underrun_q, underrun_d, late_q, late_d;
    logic               tick_c, pop_c, load_empty_c, accept_c, drop_c, full_c;

    // Free-running slot counter, independent of the FSM.
    always_comb begin
        tick_c = (cnt_q == CNT_LAST);
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        ack_cnt_d    = ack_cnt_q;
        dac_data_d   = dac_data_q;
        dac_send_d   = 1'b0;
        pop_c        = 1'b0;
        load_empty_c = 1'b0;
        unique case (state_q)
            IDLE: if (tick_c) state_d = LOAD;
            LOAD: begin
                if (level_q != '0) begin
                    pop_c      = 1'b1;
                    dac_data_d = {CHANNEL_CMD, mem_q[rd_ptr_q]};
                end else begin
                    load_empty_c = 1'b1;
                end
                dac_send_d = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                ack_cnt_d = '0;
                state_d   = ACK;
            end
            ACK: begin
                if (bus.dac_busy) begin
                    state_d = DONE;
                end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            DONE: if (!bus.dac_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping: a pop in the same cycle frees the slot for a push into a full FIFO.
    always_comb begin
        full_c   = (level_q == LVL_W'(DEPTH));
        accept_c = bus.sample_valid && (!full_c || pop_c);
        drop_c   = bus.sample_valid && full_c && !pop_c;
        wr_ptr_d = accept_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        if (accept_c && !pop_c)      level_d = level_q + LVL_W'(1);
        else if (!accept_c && pop_c) level_d = level_q - LVL_W'(1);
    end

    // Sticky flags: a set event wins over a simultaneous clear.
    always_comb begin
        overflow_d = drop_c ? 1'b1 : (clear_flags ? 1'b0 : overflow_q);
        underrun_d = load_empty_c ? 1'b1 : (clear_flags ? 1'b0 : underrun_q);
        late_d     = (tick_c && state_q != IDLE) ? 1'b1 : (clear_flags ? 1'b0 : late_q);
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ack_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dac_data_q <= '0;
            dac_send_q <= 1'b0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_cnt_q  <= ack_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dac_data_q <= dac_data_d;
            dac_send_q <= dac_send_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            late_q     <= late_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (accept_c) mem_q[wr_ptr_q] <= bus.sample_in;
    end

    assign bus.dac_data = dac_data_q;
    assign bus.dac_send = dac_send_q;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign underrun     = underrun_q;
    assign late         = late_q;
endmodule

// File: tb/tb_dac_sample_pacer.sv
// Scoreboard bench for dac_sample_pacer with a 16-cycle send interval and a simple DAC busy model.
module tb_dac_sample_pacer;
    localparam int unsigned N = 16;

    logic       clock = 1'b0;
    logic       rstn;
    logic       clear_flags;
    logic [2:0] fifo_level;
    logic       overflow, underrun, late;

    dac_sample_pacer_if ifc();

    dac_sample_pacer #(.SEND_INTERVAL(N), .CHANNEL_CMD(8'h31)) dut (
        .clock       (clock),
        .rstn        (rstn),
        .bus         (ifc),
        .clear_flags (clear_flags),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underrun    (underrun),
        .late        (late)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_mode = 0;   // 0: busy 10 cycles, 1: busy 40 cycles, 2: busy tied low
    logic [23:0] exp_q[$];
    logic        prev_send = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle index since reset release; equals the DUT slot counter value.
    always @(posedge clock) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // DAC busy model: high from the cycle after dac_send for the configured length.
    initial begin
        int left;
        left = 0;
        ifc.dac_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (!rstn) begin
                left = 0;
                ifc.dac_busy = 1'b0;
            end else if (ifc.dac_send && busy_mode != 2) begin
                left = (busy_mode == 1) ? 41 : 11;
                ifc.dac_busy = 1'b1;
            end else if (left > 0) begin
                left--;
                if (left == 0) ifc.dac_busy = 1'b0;
            end
        end
    end

    // Monitor: every dac_send pops one expected word and must land in slot position 1.
    always @(negedge clock) begin
        if (!rstn) begin
            prev_send = 1'b0;
        end else begin
            if (ifc.dac_send) begin
                check("send_gap", 32'(prev_send), 32'd0);
                check("send_slot", 32'(cyc % N), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send actual=%h expected=none (cyc %0d)", ifc.dac_data, cyc);
                end else begin
                    check("dac_data", 32'(ifc.dac_data), 32'(exp_q.pop_front()));
                end
            end
            prev_send = ifc.dac_send;
        end
    end

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clock);
        if (cyc != c) begin
            checks++;
            errors++;
            $display("FAIL goto actual=%0d expected=%0d", cyc, c);
        end
    endtask

    task automatic push(input logic [15:0] d);
        ifc.sample_valid = 1'b1;
        ifc.sample_in    = d;
        @(negedge clock);
        ifc.sample_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        clear_flags = 1'b0;
        ifc.sample_valid = 1'b0;
        ifc.sample_in = '0;
        repeat (3) @(negedge clock);
        check("rst_data", 32'(ifc.dac_data), 32'h0);
        check("rst_send", 32'(ifc.dac_send), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_flags", 32'({overflow, underrun, late}), 32'h0);
        rstn = 1'b1;

        // Single sample sent on the first slot.
        goto_cyc(2);
        exp_q.push_back(24'h311234);
        push(16'h1234);
        check("level_one", 32'(fifo_level), 32'd1);
        goto_cyc(17);
        check("level_after_send", 32'(fifo_level), 32'd0);

        // Five back-to-back pushes: E overflows, A..D go out on the next slots.
        goto_cyc(18);
        push(16'hAAA1); push(16'hAAA2); push(16'hAAA3); push(16'hAAA4); push(16'hAAA5);
        exp_q.push_back(24'h31AAA1); exp_q.push_back(24'h31AAA2);
        exp_q.push_back(24'h31AAA3); exp_q.push_back(24'h31AAA4);
        check("level_full", 32'(fifo_level), 32'd4);
        check("overflow_set", 32'(overflow), 32'd1);
        goto_cyc(24);
        pulse_clear();
        check("overflow_clr", 32'(overflow), 32'd0);
        goto_cyc(81);
        check("level_drained", 32'(fifo_level), 32'd0);

        // BEEF then nothing: the next slot resends it and flags underrun.
        goto_cyc(82);
        exp_q.push_back(24'h31BEEF);
        exp_q.push_back(24'h31BEEF);
        exp_q.push_back(24'h31BEEF);
        push(16'hBEEF);
        goto_cyc(98);
        check("underrun_clean", 32'(underrun), 32'd0);
        goto_cyc(113);
        check("underrun_set", 32'(underrun), 32'd1);
        goto_cyc(114);
        pulse_clear();
        check("underrun_clr", 32'(underrun), 32'd0);

        // Long busy after slot 8: slots 9 and 10 are discarded as late.
        goto_cyc(120);
        busy_mode = 1;
        goto_cyc(130);
        check("late_clean", 32'(late), 32'd0);
        goto_cyc(144);
        check("late_set", 32'(late), 32'd1);

        // Busy tied low: ACK times out and the next slot proceeds normally.
        goto_cyc(172);
        busy_mode = 2;
        exp_q.push_back(24'h315A5A);
        exp_q.push_back(24'h315A5A);
        clear_flags = 1'b1;
        push(16'h5A5A);
        clear_flags = 1'b0;
        check("flags_clr", 32'({overflow, underrun, late}), 32'h0);
        goto_cyc(192);
        check("late_timeout", 32'(late), 32'd0);
        goto_cyc(194);
        busy_mode = 0;
        goto_cyc(199);
        pulse_clear();

        // Full FIFO with push and LOAD pop together, then reset while in ACK.
        push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
        exp_q.push_back(24'h310001);
        check("level_full2", 32'(fifo_level), 32'd4);
        check("underrun_clr2", 32'(underrun), 32'd0);
        goto_cyc(208);
        push(16'h0005);
        check("level_pushpop", 32'(fifo_level), 32'd4);
        check("overflow_pushpop", 32'(overflow), 32'd0);
        goto_cyc(210);
        rstn = 1'b0;
        @(negedge clock);
        check("midrst_data", 32'(ifc.dac_data), 32'h0);
        check("midrst_send", 32'(ifc.dac_send), 32'h0);
        check("midrst_level", 32'(fifo_level), 32'h0);
        check("midrst_flags", 32'({overflow, underrun, late}), 32'h0);
        repeat (2) @(negedge clock);
        rstn = 1'b1;

        // After reset the old FIFO contents are gone and the first slot is a full interval away.
        goto_cyc(3);
        exp_q.push_back(24'h31CAFE);
        push(16'hCAFE);
        check("level_post_rst", 32'(fifo_level), 32'd1);
        goto_cyc(20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_sample_pacer.md
DAC_SAMPLE_PACER -- requirements
Module: dac_sample_pacer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter SEND_INTERVAL, default 3624: clock cycles between DAC send slots.
REQ-003 Parameter CHANNEL_CMD, default 8'b00110001: command byte prefixed to every DAC word (write channel A).
REQ-004 clock  input  1  system clock (88.67 MHz internal oscillator); all logic on its rising edge.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 sample_in  input  16  ADC sample; valid only when sample_valid=1.
REQ-007 sample_valid  input  1  single-cycle pulse from ADC receiver marking a new sample.
REQ-008 dac_busy  input  1  high while the DAC SPI transmitter is shifting a word.
REQ-009 clear_flags  input  1  single-cycle pulse clearing sticky status flags.
REQ-010 dac_data  output  24  {CHANNEL_CMD, sample} word presented to the DAC transmitter.
REQ-011 dac_send  output  1  single-cycle start pulse to the DAC transmitter.
REQ-012 fifo_level  output  3  current FIFO occupancy, 0..4.
REQ-013 overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-014 underrun  output  1  sticky: a send slot found the FIFO empty.
REQ-015 late  output  1  sticky: a send slot occurred while a previous transfer was still in progress.

Function
REQ-016 A 4-entry, 16-bit FIFO SHALL buffer samples; a push happens on sample_valid=1.
REQ-017 The interval counter SHALL count 0..SEND_INTERVAL-1 and wrap; a tick occurs in the cycle it equals SEND_INTERVAL-1.
REQ-018 The counter SHALL run freely, independent of FSM state.
REQ-019 FSM states: IDLE, LOAD, SEND, ACK, DONE.
REQ-020 IDLE -> LOAD on tick; with no tick, stay in IDLE.
REQ-021 LOAD (one cycle), FIFO non-empty: pop the head entry and register dac_data <= {CHANNEL_CMD, head}.
REQ-022 LOAD, FIFO empty: leave dac_data unchanged (previous sample resent) and set underrun.
REQ-023 SEND SHALL drive dac_send=1 for exactly one cycle, then go to ACK.
REQ-024 Latency: tick in cycle N -> dac_data updated at end of N+1 -> dac_send=1 in cycle N+2.
REQ-025 ACK -> DONE when dac_busy=1.
REQ-026 ACK -> IDLE if dac_busy stays 0 for 4 consecutive ACK cycles (timeout; no flag).
REQ-027 DONE -> IDLE when dac_busy=0.
REQ-028 A tick in any state other than IDLE SHALL be discarded and set late; the FSM does not queue it.
REQ-029 Push while full with no pop in the same cycle: drop the sample, set overflow, leave FIFO contents unchanged.
REQ-030 Push and pop in the same cycle: both take effect, fifo_level unchanged; this applies when full, because the pop frees the slot.
REQ-031 Push and pop in the same cycle with the FIFO empty is impossible, since pop requires non-empty; the push is accepted.
REQ-032 FIFO pointers SHALL be 2 bits and wrap modulo 4.
REQ-033 fifo_level SHALL be registered and reflect all pushes and pops completed by the previous edge.
REQ-034 clear_flags SHALL clear overflow, underrun and late on the next edge; a set event in the same cycle wins.
REQ-035 dac_send SHALL never be asserted in two consecutive cycles.

Reset
REQ-036 While rstn=0 at a clock edge, the block SHALL go to: state IDLE, counter 0, FIFO empty.
REQ-037 The same reset edge SHALL clear dac_data=24'h000000, dac_send=0, fifo_level=0, overflow=0, underrun=0, late=0.
REQ-038 Reset asserted mid-transfer (SEND/ACK/DONE) SHALL force dac_send=0 from the next cycle; FIFO contents are discarded.
REQ-039 After rstn rises, the first tick SHALL occur SEND_INTERVAL cycles later.

Verification (SEND_INTERVAL=16; dac_busy model rises 1 cycle after dac_send and stays high 10 cycles)
REQ-040 Push 16'h1234 before the first tick -> dac_data=24'h311234 and dac_send pulse at tick+2; fifo_level 1 -> 0.
REQ-041 Push 5 samples A..E back-to-back with no tick -> overflow=1, fifo_level=4; A,B,C,D are sent on the next four slots; E is never sent.
REQ-042 Send 16'hBEEF, then no further pushes -> next slot resends 24'h31BEEF and underrun=1; clear_flags -> underrun=0.
REQ-043 Hold dac_busy high for 40 cycles after a send -> the tick during DONE sets late=1 and produces no extra dac_send.
REQ-044 Tie dac_busy=0 -> FSM returns to IDLE 4 cycles after SEND; exactly one dac_send per slot.
REQ-045 Hit full FIFO with push and LOAD pop in the same cycle -> no overflow, fifo_level stays 4; then reset during ACK -> all outputs 0 and fifo_level=0 next cycle.
